// File: rtl/kyber_codec_pkg.sv
// Shared types and the Kyber 1-bit compress/decompress rules used by the message codec.
// The thresholds come from the modulus argument, so a different Q needs no new constants.
package kyber_codec_pkg;

  localparam int unsigned KYBER_Q      = 3329;
  localparam int unsigned KYBER_COEF_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEC_OUT = 2'd1,
    ENC_IN  = 2'd2,
    ENC_OUT = 2'd3
  } state_t;

  typedef logic [KYBER_COEF_W-1:0] coef_t;

  // round(2x/q) mod 2 is 1 exactly on the band ceil(q/4) .. floor(3q/4)
  function automatic logic compress1(coef_t x, int unsigned q = KYBER_Q);
    int unsigned lo;
    int unsigned hi;
    lo = (q + 3) / 4;
    hi = (3 * q) / 4;
    return (32'(x) >= lo) && (32'(x) <= hi);
  endfunction

  function automatic coef_t decompress1(logic b, int unsigned q = KYBER_Q);
    return b ? coef_t'((q + 1) / 2) : coef_t'(0);
  endfunction

endpackage

// File: rtl/msg_lane_codec.sv
// Combinational LANES-wide Compress_1 / Decompress_1 with an out-of-range flag.
module msg_lane_codec
  import kyber_codec_pkg::*;
#(
  parameter int          LANES  = 8,
  parameter int          COEF_W = 12,
  parameter int unsigned Q      = KYBER_Q
) (
  input  logic [LANES-1:0]        dec_bits,
  output logic [LANES*COEF_W-1:0] dec_coefs,
  input  logic [LANES*COEF_W-1:0] enc_coefs,
  output logic [LANES-1:0]        enc_bits,
  output logic                    enc_range_err
);

  logic [LANES-1:0] lane_oob;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      coef_t x;
      assign x             = enc_coefs[gi*COEF_W +: COEF_W];
      assign lane_oob[gi]  = (32'(x) >= Q);
      // Out-of-range inputs are forced to 0 rather than trusting the band test
      assign enc_bits[gi]  = !lane_oob[gi] && compress1(x, Q);
      assign dec_coefs[gi*COEF_W +: COEF_W] = decompress1(dec_bits[gi], Q);
    end
  endgenerate

  assign enc_range_err = |lane_oob;

endmodule

// File: rtl/msg_codec_stream.sv
// Streaming Kyber message codec: DECODE turns an N-bit message into coefficient beats,
// ENCODE compresses coefficient beats back into an N-bit message.
module msg_codec_stream
  import kyber_codec_pkg::*;
#(
  parameter int          N      = 256,
  parameter int unsigned Q      = KYBER_Q,
  parameter int          COEF_W = 12,
  parameter int          LANES  = 8,
  parameter int unsigned HALF_Q = (Q + 1) / 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [N-1:0]            msg_in,
  input  logic                    msg_in_valid,
  output logic                    msg_in_ready,
  input  logic [LANES*COEF_W-1:0] coef_in,
  input  logic                    coef_in_valid,
  output logic                    coef_in_ready,
  output logic [LANES*COEF_W-1:0] coef_out,
  output logic                    coef_out_valid,
  input  logic                    coef_out_ready,
  output logic                    coef_out_last,
  output logic [N-1:0]            msg_out,
  output logic                    msg_out_valid,
  input  logic                    msg_out_ready,
  output logic                    busy,
  output logic                    range_err
);

  localparam int BEATS = N / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  generate
    if (N % LANES != 0) begin : g_bad_lanes
      $error("msg_codec_stream: N must be a multiple of LANES");
    end
    if (COEF_W != KYBER_COEF_W) begin : g_bad_coef_w
      $error("msg_codec_stream: COEF_W must match kyber_codec_pkg::coef_t");
    end
    if (HALF_Q != (Q + 1) / 2) begin : g_bad_half_q
      $error("msg_codec_stream: HALF_Q must equal (Q+1)/2");
    end
  endgenerate

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   beat_cnt_reg;
  logic [N-1:0]       msg_reg;
  logic [N-1:0]       msg_shift_next;
  logic [N-1:0]       msg_absorb_next;
  logic               range_err_reg;
  logic               beat_last;
  logic               msg_in_fire;
  logic               coef_in_fire;
  logic               coef_out_fire;

  logic [LANES*COEF_W-1:0] dec_coefs;
  logic [LANES-1:0]        enc_bits;
  logic                    enc_range_err;

  // msg_reg is a shift register: DECODE consumes the low LANES bits each beat,
  // ENCODE shifts new bits in at the top so beat 0 ends up at bit 0.
  msg_lane_codec #(
    .LANES  (LANES),
    .COEF_W (COEF_W),
    .Q      (Q)
  ) u_lane_codec (
    .dec_bits      (msg_reg[LANES-1:0]),
    .dec_coefs     (dec_coefs),
    .enc_coefs     (coef_in),
    .enc_bits      (enc_bits),
    .enc_range_err (enc_range_err)
  );

  assign beat_last = (beat_cnt_reg == LAST_BEAT);

  always_comb begin
    msg_shift_next  = msg_reg >> LANES;
    msg_absorb_next = msg_shift_next;
    msg_absorb_next[N-1 -: LANES] = enc_bits;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    msg_in_ready   = 1'b0;
    coef_in_ready  = 1'b0;
    coef_out_valid = 1'b0;
    msg_out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        msg_in_ready  = !mode;
        coef_in_ready = mode;
        if (!mode && msg_in_valid) begin
          state_next = DEC_OUT;
        end else if (mode && coef_in_valid) begin
          state_next = beat_last ? ENC_OUT : ENC_IN;
        end
      end
      DEC_OUT: begin
        coef_out_valid = 1'b1;
        if (coef_out_ready && beat_last) begin
          state_next = IDLE;
        end
      end
      ENC_IN: begin
        coef_in_ready = 1'b1;
        if (coef_in_valid && beat_last) begin
          state_next = ENC_OUT;
        end
      end
      ENC_OUT: begin
        msg_out_valid = 1'b1;
        if (msg_out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign msg_in_fire   = msg_in_valid && msg_in_ready;
  assign coef_in_fire  = coef_in_valid && coef_in_ready;
  assign coef_out_fire = coef_out_valid && coef_out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_reg  <= '0;
      msg_reg       <= '0;
      range_err_reg <= 1'b0;
    end else begin
      if (msg_in_fire) begin
        msg_reg      <= msg_in;
        beat_cnt_reg <= '0;
      end
      if (coef_in_fire) begin
        msg_reg      <= msg_absorb_next;
        beat_cnt_reg <= beat_last ? '0 : beat_cnt_reg + 1'b1;
        if (enc_range_err) begin
          range_err_reg <= 1'b1;
        end
      end
      if (coef_out_fire) begin
        msg_reg      <= msg_shift_next;
        beat_cnt_reg <= beat_last ? '0 : beat_cnt_reg + 1'b1;
      end
    end
  end

  // Payloads read as zero whenever their valid is low
  assign coef_out      = coef_out_valid ? dec_coefs : '0;
  assign coef_out_last = coef_out_valid && beat_last;
  assign msg_out       = msg_out_valid ? msg_reg : '0;
  assign busy          = (state_reg != IDLE);
  assign range_err     = range_err_reg;

endmodule

// File: doc/msg_codec_stream.md
Name: msg_codec_stream

Overview:
- Streaming, parametrised successor to the combinational Kyber message decoder.
- DECODE mode: takes one N-bit message and emits the Decompress_1 polynomial (bit b -> b*ceil(Q/2)) as N/LANES beats of LANES coefficients.
- ENCODE mode: takes N/LANES coefficient beats, applies Compress_1 (round(2x/Q) mod 2) and emits one N-bit message.
- Sits between the message/hash interface and the NTT/poly datapath; ready/valid on every side.

Parameters:
- N, 256, coefficients per polynomial (= message bits).
- Q, 3329, modulus.
- COEF_W, 12, coefficient width.
- LANES, 8, coefficients per beat. N % LANES == 0 is enforced by an elaboration-time $error.
- HALF_Q, (Q+1)/2 = 1665, decode value for bit 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- mode  in  1  0 = DECODE, 1 = ENCODE; sampled only in IDLE
- msg_in  in  N  message for DECODE
- msg_in_valid  in  1  handshake
- msg_in_ready  out  1  handshake
- coef_in  in  LANES*COEF_W  coefficient beat for ENCODE
- coef_in_valid  in  1  handshake
- coef_in_ready  out  1  handshake
- coef_out  out  LANES*COEF_W  decoded coefficient beat
- coef_out_valid  out  1  handshake
- coef_out_ready  in  1  handshake
- coef_out_last  out  1  marks final beat
- msg_out  out  N  encoded message
- msg_out_valid  out  1  handshake
- msg_out_ready  in  1  handshake
- busy  out  1  state != IDLE
- range_err  out  1  sticky; an ENCODE input coefficient was >= Q

Behaviour:
- Ordering: lane i of beat b is coefficient k = b*LANES+i, carried in bits [i*COEF_W +: COEF_W]; msg bit k maps to coefficient k.
- Reset (rst_n=0 at a clk edge, including mid-operation):
  - state=IDLE, beat_cnt=0.
  - All valid outputs 0, coef_out/msg_out/range_err 0.
  - Any partial transfer is discarded.
- States:
  - IDLE:
    - msg_in_ready = !mode; coef_in_ready = mode.
    - DECODE: msg_in handshake latches msg into shift register -> DEC_OUT.
    - ENCODE: coef_in handshake -> ENC_IN, beat 0 absorbed.
  - DEC_OUT:
    - coef_out_valid=1; coef_out is built from msg bits [beat_cnt*LANES +: LANES].
    - On a coef_out handshake, beat_cnt increments.
    - The handshake with beat_cnt = N/LANES-1 (coef_out_last=1) -> IDLE, beat_cnt=0.
  - ENC_IN:
    - coef_in_ready=1. Each handshake writes LANES compressed bits into msg_reg at beat_cnt*LANES.
    - The last beat -> ENC_OUT.
  - ENC_OUT:
    - msg_out_valid=1, msg_out=msg_reg.
    - Handshake -> IDLE.
    - msg_in_ready/coef_in_ready = 0.
- Compress_1 per lane: bit = 1 iff 833 <= x <= 2496, i.e. ceil(Q/4) .. floor(3Q/4). Constants are derived from Q at elaboration.
- x >= Q: bit = 0, range_err set. range_err clears only on reset.
- Latency:
  - DECODE: msg accepted at edge t -> first coef beat valid after edge t; N/LANES beats minimum at full throughput.
  - ENCODE: last coef beat accepted at edge t -> msg_out_valid after edge t.
- Backpressure: outputs and their payloads hold stable while valid && !ready. No bubble between consecutive DEC_OUT beats.
- mode changes outside IDLE are ignored. The ready signal of the inactive input is 0 in every state.
- Simultaneous msg_in_valid and coef_in_valid in IDLE: only the input selected by mode is acknowledged.
- Back-to-back transactions: the IDLE cycle after completion is mandatory (one-cycle gap).

Decomposition:
- Package kyber_codec_pkg:
  - typedef state_t {IDLE, DEC_OUT, ENC_IN, ENC_OUT}
  - typedef coef_t logic [COEF_W-1:0]
  - functions compress1(coef_t) -> logic and decompress1(logic) -> coef_t, with thresholds derived from Q.
- One sub-module, msg_lane_codec: combinational LANES-wide compress/decompress plus range flag, instantiated once.
- FSM, counter and registers stay in the top level.

Test Plan:
- DECODE, LANES=8, msg low byte 8'hFA, rest 0:
  - beat0 lanes 0..7 = 0,1665,0,1665,1665,1665,1665,1665.
  - Beats 1..31 all 0; coef_out_last only on beat 31.
- ENCODE lane boundaries:
  - beat0 = {0,832,833,1665,2496,2497,3328,1} -> msg bits[7:0] = 8'b00011100.
  - Other beats 0 -> msg_out rest 0; range_err stays 0.
- Round trip: random 256-bit msg DECODEd, the stream fed into ENCODE -> msg_out equals the original; 100 seeds.
- Backpressure: coef_out_ready toggled 1/0 pseudo-randomly in DECODE -> payload stable while stalled, exactly 32 handshakes, same data as unstalled run.
- Range error: ENCODE with a lane = 3329 -> that bit = 0, range_err=1 and sticky through the next transaction.
- Reset mid-op: rst_n low during DEC_OUT beat 10 and during ENC_IN beat 5 -> next cycle state IDLE, all valids 0. A fresh transaction then completes correctly.
